// File: rtl/rv_regs_pkg.sv
// Shared types and constants for the FlexRV32 multi-port register file.
package rv_regs_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RV32E_NREGS = 16;

  typedef logic [4:0]          reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // True when an index names a real, writable register for the given
  // register count: x0 is never stored, and RV32E has no x16..x31.
  function automatic logic idx_storable(reg_idx_t idx, int nregs);
    return (idx != REG_ZERO) && !((nregs == RV32E_NREGS) && idx[4]);
  endfunction

endpackage

// File: rtl/rv_regs_scoreboard.sv
// Per-register pending bits for long-latency results, with a busy lookup
// for the read addresses selected this cycle.
module rv_regs_scoreboard
  import rv_regs_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int RD_PORTS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pend_set,
  input  logic [4:0]            pend_rd,
  input  logic                  clr_en,
  input  logic [4:0]            clr_rd,
  input  logic [RD_PORTS*5-1:0] rd_idx,
  output logic [RD_PORTS-1:0]   busy
);

  // x0 has no pending bit; out-of-range RV32E indices never match a bit.
  logic [NREGS-1:1] pend;
  logic [NREGS-1:1] pend_next;

  // Clear first, then set, so a newly issued op wins over a same-cycle writeback.
  always_comb begin
    pend_next = pend;
    for (int r = 1; r < NREGS; r++) begin
      if (clr_en && (clr_rd == reg_idx_t'(r)))
        pend_next[r] = 1'b0;
      if (pend_set && (pend_rd == reg_idx_t'(r)))
        pend_next[r] = 1'b1;
    end
  end

  // Busy reflects the state after this cycle's set/clear so a read in the clear cycle sees not-busy.
  always_comb begin
    busy = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (rd_idx[i*5 +: 5] == reg_idx_t'(r))
          busy[i] = pend_next[r];
      end
    end
  end

  // Pending bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend <= '0;
    else
      pend <= pend_next;
  end

endmodule

// File: rtl/rv_regs_mp.sv
// Multi-port integer register file with registered reads, hold mode,
// write-to-read bypass and a pending scoreboard.
module rv_regs_mp
  import rv_regs_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_rs_valid,
  input  logic [RD_PORTS*5-1:0]    i_rs,
  input  logic [WR_PORTS-1:0]      i_wr_en,
  input  logic [WR_PORTS*5-1:0]    i_wr_rd,
  input  logic [WR_PORTS*XLEN-1:0] i_wr_data,
  input  logic                     i_pend_set,
  input  logic [4:0]               i_pend_rd,
  output logic [RD_PORTS*XLEN-1:0] o_data,
  output logic [RD_PORTS-1:0]      o_busy,
  output logic                     o_illegal
);

  localparam bit RV32E = (NREGS == RV32E_NREGS);
  localparam int LATE  = WR_PORTS - 1;

  logic [XLEN-1:0]          regs [1:NREGS-1];
  logic [RD_PORTS*5-1:0]    cap_rs;
  logic [RD_PORTS*5-1:0]    sel_rs;
  logic [RD_PORTS*XLEN-1:0] data_next;
  logic [RD_PORTS-1:0]      busy_next;
  logic                     illegal_next;

  // While stalled the captured addresses are re-read so outputs track writebacks.
  always_comb begin
    sel_rs = i_rs_valid ? i_rs : cap_rs;
  end

  // Array lookup, then optional forwarding of this cycle's writes; later ports override earlier ones.
  always_comb begin
    data_next = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (sel_rs[i*5 +: 5] == reg_idx_t'(r))
          data_next[i*XLEN +: XLEN] = regs[r];
      end
      if (BYPASS != 0) begin
        for (int p = 0; p < WR_PORTS; p++) begin
          if (i_wr_en[p] && (i_wr_rd[p*5 +: 5] == sel_rs[i*5 +: 5]) &&
              idx_storable(sel_rs[i*5 +: 5], NREGS))
            data_next[i*XLEN +: XLEN] = i_wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Flag any RV32E access that names x16..x31; always quiet for RV32I.
  always_comb begin
    illegal_next = 1'b0;
    if (RV32E) begin
      for (int i = 0; i < RD_PORTS; i++)
        if (i_rs_valid && i_rs[i*5 + 4])
          illegal_next = 1'b1;
      for (int p = 0; p < WR_PORTS; p++)
        if (i_wr_en[p] && i_wr_rd[p*5 + 4])
          illegal_next = 1'b1;
      if (i_pend_set && i_pend_rd[4])
        illegal_next = 1'b1;
    end
  end

  rv_regs_scoreboard #(
    .NREGS    (NREGS),
    .RD_PORTS (RD_PORTS)
  ) u_scoreboard (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .pend_set (i_pend_set),
    .pend_rd  (i_pend_rd),
    .clr_en   (i_wr_en[LATE]),
    .clr_rd   (i_wr_rd[LATE*5 +: 5]),
    .rd_idx   (sel_rs),
    .busy     (busy_next)
  );

  // Register array update; iterating ports in order lets the higher port win a conflict.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int r = 1; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        for (int p = 0; p < WR_PORTS; p++) begin
          if (i_wr_en[p] && (i_wr_rd[p*5 +: 5] == reg_idx_t'(r)))
            regs[r] <= i_wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Captured addresses and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cap_rs    <= '0;
      o_data    <= '0;
      o_busy    <= '0;
      o_illegal <= 1'b0;
    end else begin
      cap_rs    <= sel_rs;
      o_data    <= data_next;
      o_busy    <= busy_next;
      o_illegal <= illegal_next;
    end
  end

endmodule
